// File: rtl/disp_pkg.sv
// Shared types and glyph constants for the CPU output display.
// Glyphs are active-high {g,f,e,d,c,b,a}.
package disp_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  typedef logic [3:0] nibble_t;
  typedef logic [$clog2(NUM_DIGITS)-1:0] digit_idx_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-high 7-segment glyph, with forced blank.
module hex_to_seg7
  import disp_pkg::*;
(
  input  nibble_t    nibble_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      unique case (nibble_i)
        4'h0: seg_o = SEG_0;
        4'h1: seg_o = SEG_1;
        4'h2: seg_o = SEG_2;
        4'h3: seg_o = SEG_3;
        4'h4: seg_o = SEG_4;
        4'h5: seg_o = SEG_5;
        4'h6: seg_o = SEG_6;
        4'h7: seg_o = SEG_7;
        4'h8: seg_o = SEG_8;
        4'h9: seg_o = SEG_9;
        4'hA: seg_o = SEG_A;
        4'hB: seg_o = SEG_B;
        4'hC: seg_o = SEG_C;
        4'hD: seg_o = SEG_D;
        4'hE: seg_o = SEG_E;
        4'hF: seg_o = SEG_F;
      endcase
    end
  end

endmodule

// File: rtl/cpu_out_display.sv
// Captures each new CPU OUT value, counts updates, and scans it onto a
// multiplexed 4-digit 7-segment display with a post-update flash on dp.
module cpu_out_display
  import disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 50000,
  parameter int unsigned FLASH_CYC   = 5000000,
  parameter bit          LEAD_BLANK  = 1'b1,
  parameter bit          SEG_ACT_LOW = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] din,
  input  logic        hold,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic [15:0] shown,
  output logic [7:0]  upd_cnt
);

  localparam int unsigned DivW   = $clog2(SCAN_DIV);
  localparam int unsigned FlashW = (FLASH_CYC > 0) ? $clog2(FLASH_CYC + 1) : 1;
  localparam logic [6:0]  SegOff = {7{SEG_ACT_LOW}};
  localparam logic [3:0]  AnOff  = {NUM_DIGITS{SEG_ACT_LOW}};

  logic [15:0]       shown_q, shown_d;
  logic [7:0]        upd_cnt_q, upd_cnt_d;
  logic [FlashW-1:0] flash_q, flash_d;
  logic [DivW-1:0]   div_q, div_d;
  digit_idx_t        idx_q, idx_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [3:0]        an_q, an_d;

  logic       capture;
  nibble_t    nibble;
  logic       blank;
  logic [6:0] seg_raw;

  // X on din makes the compare unknown, which the if below treats as no capture.
  always_comb begin
    capture   = 1'b0;
    shown_d   = shown_q;
    upd_cnt_d = upd_cnt_q;
    flash_d   = flash_q;
    if (!hold && (din != shown_q)) begin
      capture = 1'b1;
    end
    if (capture) begin
      shown_d = din;
      flash_d = FlashW'(FLASH_CYC);
      if (upd_cnt_q != 8'hFF) begin
        upd_cnt_d = upd_cnt_q + 8'd1;
      end
    end else if (flash_q != '0) begin
      flash_d = flash_q - 1'b1;
    end
  end

  always_comb begin
    div_d = div_q + 1'b1;
    idx_d = idx_q;
    if (div_q == DivW'(SCAN_DIV - 1)) begin
      div_d = '0;
      idx_d = idx_q + 1'b1;
    end
  end

  // Outputs are built from the current index and value, so an and seg move together.
  always_comb begin
    nibble = shown_q[{idx_q, 2'b00} +: 4];
    blank  = LEAD_BLANK && (idx_q != '0) && ((shown_q >> {idx_q, 2'b00}) == 16'h0);
    seg_d  = seg_raw ^ SegOff;
    dp_d   = ((idx_q == '0) && (flash_q != '0)) ^ SEG_ACT_LOW;
    an_d   = (4'b0001 << idx_q) ^ AnOff;
  end

  hex_to_seg7 u_hex_to_seg7 (
    .nibble_i (nibble),
    .blank_i  (blank),
    .seg_o    (seg_raw)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shown_q   <= '0;
      upd_cnt_q <= '0;
      flash_q   <= '0;
      div_q     <= '0;
      idx_q     <= '0;
      seg_q     <= SegOff;
      dp_q      <= SEG_ACT_LOW;
      an_q      <= AnOff;
    end else begin
      shown_q   <= shown_d;
      upd_cnt_q <= upd_cnt_d;
      flash_q   <= flash_d;
      div_q     <= div_d;
      idx_q     <= idx_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      an_q      <= an_d;
    end
  end

  assign seg     = seg_q;
  assign dp      = dp_q;
  assign an      = an_q;
  assign shown   = shown_q;
  assign upd_cnt = upd_cnt_q;

endmodule
